// File: rtl/tdm_pkg.sv
// Shared types and constants for the 3-stream TDM slot scheduler.
package tdm_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SLOT_START = 2'd1,
    SLOT_HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_1S  = 2'd1;
  localparam logic [1:0] MODE_2S  = 2'd2;
  localparam logic [1:0] MODE_3S  = 2'd3;

  typedef logic [1:0] stream_idx_t;

  localparam logic [7:0] DEF_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/tdm_slot_timer.sv
// Loadable down-counter that flags the last cycle of a slot.
// Loading happens in the slot's first cycle, so a length of 1 is flagged immediately.
module tdm_slot_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             slot_last
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= len - CNT_W'(1);
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign slot_last = load ? (len == CNT_W'(1)) : (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/tdm_slot_scheduler.sv
// Frame-level slot scheduler for the 3-stream TDM multiplexer.
// Optional per-stream underflow counters: define TDM_UNDERFLOW_STATS_EN.
module tdm_slot_scheduler
  import tdm_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                CNT_W     = 3,
  parameter logic [DATA_W-1:0] IDLE_BYTE = DATA_W'(DEF_IDLE_BYTE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  slot_cycles,
  input  logic [DATA_W-1:0] ds1_data,
  input  logic [DATA_W-1:0] ds2_data,
  input  logic [DATA_W-1:0] ds3_data,
  input  logic              ds1_valid,
  input  logic              ds2_valid,
  input  logic              ds3_valid,
  output logic              ds1_ready,
  output logic              ds2_ready,
  output logic              ds3_ready,
  output logic [DATA_W-1:0] mux_data,
  output logic              mux_valid,
  output logic [1:0]        mux_sel,
  output logic              slot_start,
  output logic              frame_start,
  output logic              underflow
`ifdef TDM_UNDERFLOW_STATS_EN
  ,
  output logic [7:0]        uf_cnt1,
  output logic [7:0]        uf_cnt2,
  output logic [7:0]        uf_cnt3
`endif
);

  state_t           state_reg, state_next;
  stream_idx_t      idx_reg, idx_next;
  logic [1:0]       act_mode_reg, act_mode_next;
  logic [CNT_W-1:0] act_len_reg, act_len_next;
  logic [CNT_W-1:0] len_eff;
  logic             frame_go;
  logic             timer_load;
  logic             slot_last;
  logic [2:0]       valid_vec;
  logic [2:0]       ready_vec;
  logic             cur_valid;
  logic [DATA_W-1:0] cur_data;

  assign valid_vec  = {ds3_valid, ds2_valid, ds1_valid};
  assign len_eff    = (slot_cycles == '0) ? CNT_W'(1) : slot_cycles;
  assign frame_go   = enable && (mode != MODE_OFF);
  assign timer_load = (state_reg == SLOT_START);

  // Ready is gated by rst so a reset landing on SLOT_START consumes nothing.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ready
      assign ready_vec[gi] = (state_reg == SLOT_START) && !rst &&
                             (idx_reg == stream_idx_t'(gi));
    end
  endgenerate

  assign ds1_ready = ready_vec[0];
  assign ds2_ready = ready_vec[1];
  assign ds3_ready = ready_vec[2];

  always_comb begin
    cur_valid = 1'b0;
    cur_data  = IDLE_BYTE;
    case (idx_reg)
      2'd0: begin cur_valid = ds1_valid; cur_data = ds1_data; end
      2'd1: begin cur_valid = ds2_valid; cur_data = ds2_data; end
      2'd2: begin cur_valid = ds3_valid; cur_data = ds3_data; end
      default: ;
    endcase
  end

  tdm_slot_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .len       (act_len_reg),
    .slot_last (slot_last)
  );

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    act_mode_next = act_mode_reg;
    act_len_next  = act_len_reg;
    case (state_reg)
      IDLE: begin
        if (frame_go) begin
          act_mode_next = mode;
          act_len_next  = len_eff;
          idx_next      = '0;
          state_next    = SLOT_START;
        end
      end
      SLOT_START, SLOT_HOLD: begin
        if (!slot_last) begin
          state_next = SLOT_HOLD;
        end else if (idx_reg != act_mode_reg - 2'd1) begin
          idx_next   = idx_reg + 2'd1;
          state_next = SLOT_START;
        end else if (frame_go) begin
          // Frame boundary: the only point where new settings take effect.
          act_mode_next = mode;
          act_len_next  = len_eff;
          idx_next      = '0;
          state_next    = SLOT_START;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      act_mode_reg <= MODE_OFF;
      act_len_reg  <= CNT_W'(1);
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      act_mode_reg <= act_mode_next;
      act_len_reg  <= act_len_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state_reg == IDLE) begin
      mux_data    <= IDLE_BYTE;
      mux_valid   <= 1'b0;
      mux_sel     <= 2'd0;
      slot_start  <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else if (state_reg == SLOT_START) begin
      mux_data    <= cur_valid ? cur_data : IDLE_BYTE;
      mux_valid   <= 1'b1;
      mux_sel     <= idx_reg + 2'd1;
      slot_start  <= 1'b1;
      frame_start <= (idx_reg == '0);
      underflow   <= !cur_valid;
    end else begin
      slot_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef TDM_UNDERFLOW_STATS_EN
  logic [7:0] uf_cnt_reg [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_uf_cnt
      always_ff @(posedge clk) begin
        if (rst) begin
          uf_cnt_reg[gi] <= 8'd0;
        end else if (ready_vec[gi] && !valid_vec[gi] && uf_cnt_reg[gi] != 8'hFF) begin
          uf_cnt_reg[gi] <= uf_cnt_reg[gi] + 8'd1;
        end
      end
    end
  endgenerate

  assign uf_cnt1 = uf_cnt_reg[0];
  assign uf_cnt2 = uf_cnt_reg[1];
  assign uf_cnt3 = uf_cnt_reg[2];
`else
  logic unused_valid;
  assign unused_valid = ^valid_vec;
`endif

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Directed bench for tdm_slot_scheduler; output cycle k=0 is the first output cycle of a run.
module tb_tdm_slot_scheduler;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [1:0] mode;
  logic [2:0] slot_cycles;
  logic [7:0] ds1_data, ds2_data, ds3_data;
  logic       ds1_valid, ds2_valid, ds3_valid;
  logic       ds1_ready, ds2_ready, ds3_ready;
  logic [7:0] mux_data;
  logic       mux_valid;
  logic [1:0] mux_sel;
  logic       slot_start, frame_start, underflow;
  logic [2:0] rdy;
`ifdef TDM_UNDERFLOW_STATS_EN
  logic [7:0] uf_cnt1, uf_cnt2, uf_cnt3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  assign rdy = {ds3_ready, ds2_ready, ds1_ready};

  always #5 clk = ~clk;

  tdm_slot_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .slot_cycles(slot_cycles),
    .ds1_data(ds1_data), .ds2_data(ds2_data), .ds3_data(ds3_data),
    .ds1_valid(ds1_valid), .ds2_valid(ds2_valid), .ds3_valid(ds3_valid),
    .ds1_ready(ds1_ready), .ds2_ready(ds2_ready), .ds3_ready(ds3_ready),
    .mux_data(mux_data), .mux_valid(mux_valid), .mux_sel(mux_sel),
    .slot_start(slot_start), .frame_start(frame_start), .underflow(underflow)
`ifdef TDM_UNDERFLOW_STATS_EN
    , .uf_cnt1(uf_cnt1), .uf_cnt2(uf_cnt2), .uf_cnt3(uf_cnt3)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string sc, input int k, input logic [7:0] e_data,
                         input logic e_valid, input logic [1:0] e_sel, input logic e_ss,
                         input logic e_fs, input logic e_uf, input logic [2:0] e_rdy);
    chk($sformatf("%s k%0d mux_data", sc, k), 32'(mux_data), 32'(e_data));
    chk($sformatf("%s k%0d mux_valid", sc, k), 32'(mux_valid), 32'(e_valid));
    chk($sformatf("%s k%0d mux_sel", sc, k), 32'(mux_sel), 32'(e_sel));
    chk($sformatf("%s k%0d slot_start", sc, k), 32'(slot_start), 32'(e_ss));
    chk($sformatf("%s k%0d frame_start", sc, k), 32'(frame_start), 32'(e_fs));
    chk($sformatf("%s k%0d underflow", sc, k), 32'(underflow), 32'(e_uf));
    chk($sformatf("%s k%0d ready", sc, k), 32'(rdy), 32'(e_rdy));
    $display("[TB] %s k=%0d data=%02h valid=%0b sel=%0d ss=%0b fs=%0b uf=%0b rdy=%03b",
             sc, k, mux_data, mux_valid, mux_sel, slot_start, frame_start, underflow, rdy);
  endtask

  // Reset, then request a run; returns in the first SLOT_START cycle.
  task automatic start(input logic [1:0] m, input logic [2:0] l);
    rst = 1'b1; enable = 1'b0;
    tick();
    rst = 1'b0; enable = 1'b1; mode = m; slot_cycles = l;
    tick();
  endtask

  initial begin
    logic [7:0] d3 [3];
    int s;
    d3[0] = 8'h11; d3[1] = 8'h22; d3[2] = 8'h33;

    rst = 1'b1; enable = 1'b0; mode = 2'd0; slot_cycles = 3'd1;
    ds1_data = 8'h00; ds2_data = 8'h00; ds3_data = 8'h00;
    ds1_valid = 1'b0; ds2_valid = 1'b0; ds3_valid = 1'b0;
    tick(); tick();
    chk_out("reset", 0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000);

    // mode 0 with enable stays idle
    rst = 1'b0; enable = 1'b1; mode = 2'd0;
    tick(); tick(); tick();
    chk_out("mode0", 0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000);

    // 1 stream, 6-cycle slots
    ds1_valid = 1'b1; ds1_data = 8'hA5;
    start(2'd1, 3'd6);
    chk("s1 first ready", 32'(rdy), 32'd1);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_out("s1", k, 8'hA5, 1'b1, 2'd1, (k % 6) == 0, (k % 6) == 0, 1'b0,
              ((k % 6) == 5) ? 3'b001 : 3'b000);
    end
    // reset landing on a SLOT_START cycle must suppress ready
    rst = 1'b1;
    #1;
    chk("s1 rst ready gate", 32'(rdy), 32'd0);
    tick();
    chk_out("s1rst", 0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000);

    // 3 streams, 2-cycle slots
    ds1_data = 8'h11; ds2_data = 8'h22; ds3_data = 8'h33;
    ds2_valid = 1'b1; ds3_valid = 1'b1;
    start(2'd3, 3'd2);
    for (int k = 0; k < 12; k++) begin
      tick();
      s = (k / 2) % 3;
      chk_out("s3", k, d3[s], 1'b1, 2'(s + 1), (k % 2) == 0, (k % 6) == 0, 1'b0,
              ((k % 2) == 1) ? 3'(1 << ((s + 1) % 3)) : 3'b000);
    end

    // 2 streams, 3-cycle slots, DS2 starved
    ds1_data = 8'h5A; ds2_valid = 1'b0; ds2_data = 8'h77;
    start(2'd2, 3'd3);
    for (int k = 0; k < 12; k++) begin
      tick();
      s = (k / 3) % 2;
      chk_out("s2uf", k, (s == 0) ? 8'h5A : 8'h00, 1'b1, 2'(s + 1), (k % 3) == 0,
              (k % 6) == 0, s == 1, ((k % 3) == 2) ? 3'(1 << ((s + 1) % 2)) : 3'b000);
`ifdef TDM_UNDERFLOW_STATS_EN
      chk($sformatf("s2uf k%0d uf_cnt2", k), 32'(uf_cnt2), 32'((k + 3) / 6));
      chk($sformatf("s2uf k%0d uf_cnt1", k), 32'(uf_cnt1), 32'd0);
`endif
    end

    // mode 3 -> 1 requested during slot idx 1; takes effect at the frame boundary
    ds2_valid = 1'b1; ds2_data = 8'h22; ds1_data = 8'h11;
    start(2'd3, 3'd2);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k < 6) begin
        s = k / 2;
        chk_out("m31", k, d3[s], 1'b1, 2'(s + 1), (k % 2) == 0, k == 0, 1'b0,
                ((k % 2) == 1) ? 3'(1 << ((s + 1) % 3)) : 3'b000);
      end else begin
        chk_out("m31", k, 8'h11, 1'b1, 2'd1, (k % 2) == 0, (k % 2) == 0, 1'b0,
                ((k % 2) == 1) ? 3'b001 : 3'b000);
      end
      if (k == 2) mode = 2'd1;
    end

    // enable dropped mid-frame: frame completes, then idle
    start(2'd2, 3'd2);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_out("endrop", k, (k < 2) ? 8'h11 : ((k < 4) ? 8'h22 : 8'h00), k < 4,
              (k < 2) ? 2'd1 : ((k < 4) ? 2'd2 : 2'd0), (k == 0) || (k == 2), k == 0,
              1'b0, (k == 1) ? 3'b010 : 3'b000);
      if (k == 1) enable = 1'b0;
    end

    // slot_cycles = 0 behaves as 1-cycle slots
    start(2'd2, 3'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_out("len0", k, ((k % 2) == 0) ? 8'h11 : 8'h22, 1'b1, 2'((k % 2) + 1), 1'b1,
              (k % 2) == 0, 1'b0, ((k % 2) == 0) ? 3'b010 : 3'b001);
    end

    // reset during SLOT_HOLD, released with enable=1, mode=2
    start(2'd3, 3'd4);
    tick();
    chk_out("rsthold pre", 0, 8'h11, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 3'b000);
    rst = 1'b1; enable = 1'b1; mode = 2'd2; slot_cycles = 3'd2;
    tick();
    chk_out("rsthold", 0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    rst = 1'b0;
    tick();
    chk_out("rsthold", 1, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b001);
    tick();
    chk_out("rsthold", 2, 8'h11, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_slot_scheduler.md
Name: tdm_slot_scheduler

Overview:
- Frame-level controller for the 3-stream TDM multiplexer.
- Owns the slot timing and the round-robin stream selection.
- Pulls one byte per slot from DS1/DS2/DS3 over a valid/ready handshake and presents the selected byte with slot and frame markers.
- Mode and slot length change only on frame boundaries; a missing byte is replaced by a filler.

Parameters:
- DATA_W, 8, width of each stream byte and of the output.
- CNT_W, 3, width of the slot-length field.
- IDLE_BYTE, 8'h00, filler byte driven on underflow or when idle.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run request, sampled in IDLE and at frame boundaries
- mode  in  2  active stream count: 0 = off, 1 = DS1, 2 = DS1/DS2, 3 = DS1/DS2/DS3
- slot_cycles  in  CNT_W  cycles per slot; 0 is treated as 1
- ds1_data, ds2_data, ds3_data  in  DATA_W  stream bytes
- ds1_valid, ds2_valid, ds3_valid  in  1  byte available
- ds1_ready, ds2_ready, ds3_ready  out  1  byte consumed this cycle when valid is also high
- mux_data  out  DATA_W  multiplexed byte (registered)
- mux_valid  out  1  scheduler running; mux_data meaningful
- mux_sel  out  2  stream carried in the current slot (1..3; 0 when idle)
- slot_start  out  1  one-cycle pulse on the first output cycle of each slot
- frame_start  out  1  one-cycle pulse on the first output cycle of slot index 0
- underflow  out  1  held for the whole slot when its stream had no valid byte

Behaviour:
- Reset values (rst high at a posedge):
  - state = IDLE; slot idx = 0.
  - mux_data = IDLE_BYTE; mux_valid = 0; mux_sel = 0.
  - slot_start, frame_start, underflow = 0; all ready = 0.
  - Reset mid-slot aborts the slot: no ready pulse in the reset cycle or the cycle after.
- FSM states: IDLE, SLOT_START, SLOT_HOLD.
- IDLE:
  - If enable=1 and mode!=0: latch act_mode = mode and act_len = max(slot_cycles, 1); set idx = 0; go to SLOT_START.
  - Otherwise stay in IDLE.
- SLOT_START (exactly one cycle):
  - ready of stream idx+1 is driven combinationally high. All other readys are 0.
  - At the clock edge:
    - mux_data <= that stream's valid ? its data : IDLE_BYTE.
    - underflow <= !valid.
    - mux_sel <= idx+1; mux_valid <= 1; slot_start <= 1; frame_start <= (idx==0).
  - Next state is SLOT_HOLD if act_len>1. If act_len==1, take the end-of-slot transition directly.
- SLOT_HOLD:
  - Lasts act_len-1 cycles.
  - mux_data, mux_sel and underflow hold; slot_start and frame_start are 0.
- Latency and slot length:
  - mux_data appears one cycle after the SLOT_START cycle.
  - Each output slot lasts exactly act_len cycles.
  - Frame length = act_mode × act_len cycles.
- End of slot:
  - If idx < act_mode-1: idx+1, go to SLOT_START.
  - Otherwise (frame boundary): re-sample enable, mode and slot_cycles.
    - enable=0 or mode=0: go to IDLE. Next cycle mux_valid=0, mux_sel=0, mux_data=IDLE_BYTE.
    - Otherwise: latch the new act_mode/act_len, set idx=0, go to SLOT_START.
- Mid-frame changes: mode, slot_cycles and enable changes are ignored until the frame boundary.
- Handshake: at most one byte is consumed per slot. A stream is never readied outside its own SLOT_START cycle.

Optional Feature:
- Macro: TDM_UNDERFLOW_STATS_EN.
- Defined:
  - Adds outputs uf_cnt1, uf_cnt2, uf_cnt3 (8 bits each).
  - Each counter increments on every SLOT_START in which that stream underflows.
  - Counters saturate at 255 and clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package tdm_pkg:
  - state enum (IDLE, SLOT_START, SLOT_HOLD).
  - mode constants MODE_OFF=0, MODE_1S=1, MODE_2S=2, MODE_3S=3.
  - stream index typedef (2 bits).
  - IDLE_BYTE default.
- Sub-module tdm_slot_timer:
  - Loadable CNT_W down-counter.
  - Inputs: load, len. Output: slot_last.
  - Instantiated once.

Test Plan:
- Mode 1, slot_cycles=6, DS1 always valid with 8'hA5:
  - mux_data=8'hA5 in 6-cycle slots.
  - ds1_ready pulses every 6 cycles.
  - frame_start coincides with every slot_start.
- Mode 3, slot_cycles=2, DS1/DS2/DS3 = 11/22/33 all valid:
  - Output sequence 11,11,22,22,33,33 repeating.
  - mux_sel 1,2,3.
  - frame_start every 6 cycles.
- Mode 2, slot_cycles=3, DS2 valid=0:
  - DS2 slots carry 8'h00 with underflow=1 for all 3 cycles.
  - ds2_ready pulses but no byte is consumed.
  - With TDM_UNDERFLOW_STATS_EN, uf_cnt2 increments once per frame.
- Mode 3 → 1 change mid-frame (during slot idx 1):
  - Remaining DS2/DS3 slots still run.
  - The new 1-stream frame starts at the next boundary.
- enable dropped mid-frame:
  - Frame completes.
  - mux_valid falls one cycle after the final slot.
  - No further ready pulses.
- rst asserted during SLOT_HOLD, then released with enable=1, mode=2:
  - All outputs return to their reset values the cycle after.
  - After release, the first slot_start comes with frame_start and mux_sel=1.
